// File: rtl/vga_fb_reader_pkg.sv
// Shared definitions for the VGA framebuffer fetch stage: FSM encoding,
// block geometry (3 x 16-bit halfwords carrying 4 x 12-bit pixels).
package vga_fb_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RESP  = 2'd2
  } fetch_state_e;

  localparam int BEATS_PER_BLOCK  = 3;
  localparam int LANE_W           = 16;
  localparam int PIXEL_W          = 12;
  localparam int PIXELS_PER_BLOCK = 4;
  localparam int BLOCK_W          = PIXEL_W * PIXELS_PER_BLOCK;
  localparam int BEAT_W           = 2;

  function automatic logic is_last_beat(input logic [BEAT_W-1:0] beat);
    return beat == BEAT_W'(BEATS_PER_BLOCK - 1);
  endfunction

endpackage

// File: rtl/vga_offset_reg.sv
// Frame-synchronous double-buffered register: writes land in pending and are
// promoted to active on a select pulse; a write in the same cycle passes through.
module vga_offset_reg #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [W-1:0] wdata,
  input  logic         sel,
  output logic [W-1:0] pending,
  output logic [W-1:0] active
);

  logic [W-1:0] pending_q, pending_d;
  logic [W-1:0] active_q, active_d;

  always_comb begin
    pending_d = we ? wdata : pending_q;
    active_d  = active_q;
    if (sel) begin
      active_d = we ? wdata : pending_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      active_q  <= '0;
    end else begin
      pending_q <= pending_d;
      active_q  <= active_d;
    end
  end

  assign pending = pending_q;
  assign active  = active_q;

endmodule

// File: rtl/vga_fb_reader.sv
// Framebuffer fetch stage: turns one 48-bit block request into three halfword
// reads and holds the double-buffered frame start offset. Optional ack timeout
// is enabled with the VGA_FB_TIMEOUT_EN macro.
module vga_fb_reader
  import vga_fb_reader_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int MEM_ADDR_W = 22,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     vga_addr,
  input  logic                  vga_sel,
  output logic [BLOCK_W-1:0]    vga_data,
  output logic                  vga_valid,
  output logic [ADDR_W-1:0]     vga_offset_in,
  input  logic                  vga_offset_sel,
  input  logic                  cfg_we,
  input  logic [ADDR_W-1:0]     cfg_wdata,
  output logic [ADDR_W-1:0]     cfg_rdata,
`ifdef VGA_FB_TIMEOUT_EN
  output logic                  err_timeout,
`endif
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic                  mem_ack,
  input  logic [LANE_W-1:0]     mem_rdata
);

  if ((64'd1 << MEM_ADDR_W) < 64'd3 * (64'd1 << ADDR_W)) begin : g_bad_addr_w
    $error("MEM_ADDR_W too small to hold 3 * block address");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  fetch_state_e            state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [MEM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                    mem_rd_q, mem_rd_d;
  logic [BLOCK_W-1:0]      vga_data_q, vga_data_d;
  logic                    vga_valid_q, vga_valid_d;

`ifdef VGA_FB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic                    err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = mem_rd_q;
    vga_data_d  = vga_data_q;
    vga_valid_d = 1'b0;
`ifdef VGA_FB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    err_d       = cfg_we ? 1'b0 : err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (vga_sel) begin
          mem_addr_d = MEM_ADDR_W'(vga_addr) * MEM_ADDR_W'(BEATS_PER_BLOCK);
          mem_rd_d   = 1'b1;
          beat_d     = '0;
          state_d    = ST_FETCH;
`ifdef VGA_FB_TIMEOUT_EN
          tmo_cnt_d  = '0;
`endif
        end
      end

      ST_FETCH: begin
        // mem_rd is always high here, so acks outside FETCH are ignored by construction
        if (mem_ack) begin
          for (int i = 0; i < BEATS_PER_BLOCK; i++) begin
            if (beat_q == BEAT_W'(i)) begin
              vga_data_d[i*LANE_W +: LANE_W] = mem_rdata;
            end
          end
          if (is_last_beat(beat_q)) begin
            mem_rd_d    = 1'b0;
            vga_valid_d = 1'b1;
            state_d     = ST_RESP;
          end else begin
            beat_d     = beat_q + BEAT_W'(1);
            mem_addr_d = mem_addr_q + MEM_ADDR_W'(1);
          end
`ifdef VGA_FB_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
`ifdef VGA_FB_TIMEOUT_EN
        else if (tmo_cnt_q == CNT_W'(TIMEOUT)) begin
          mem_rd_d    = 1'b0;
          vga_data_d  = '0;
          vga_valid_d = 1'b1;
          state_d     = ST_RESP;
          err_d       = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
`endif
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        mem_rd_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      vga_data_q  <= '0;
      vga_valid_q <= 1'b0;
`ifdef VGA_FB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      vga_data_q  <= vga_data_d;
      vga_valid_q <= vga_valid_d;
`ifdef VGA_FB_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  vga_offset_reg #(
    .W (ADDR_W)
  ) u_offset (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (cfg_we),
    .wdata   (cfg_wdata),
    .sel     (vga_offset_sel),
    .pending (cfg_rdata),
    .active  (vga_offset_in)
  );

  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign vga_data  = vga_data_q;
  assign vga_valid = vga_valid_q;
`ifdef VGA_FB_TIMEOUT_EN
  assign err_timeout = err_q;
`endif

endmodule

// File: tb/tb_vga_fb_reader.sv
// Randomized self-checking bench for vga_fb_reader against a block-level
// reference: expected reads are 3a..3a+2 and data is the concatenated memory words.
module tb_vga_fb_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] vga_addr = '0;
  logic        vga_sel = 1'b0;
  logic [47:0] vga_data;
  logic        vga_valid;
  logic [19:0] vga_offset_in;
  logic        vga_offset_sel = 1'b0;
  logic        cfg_we = 1'b0;
  logic [19:0] cfg_wdata = '0;
  logic [19:0] cfg_rdata;
  logic [21:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
`ifdef VGA_FB_TIMEOUT_EN
  logic        err_timeout;
`endif

  vga_fb_reader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .vga_addr       (vga_addr),
    .vga_sel        (vga_sel),
    .vga_data       (vga_data),
    .vga_valid      (vga_valid),
    .vga_offset_in  (vga_offset_in),
    .vga_offset_sel (vga_offset_sel),
    .cfg_we         (cfg_we),
    .cfg_wdata      (cfg_wdata),
    .cfg_rdata      (cfg_rdata),
`ifdef VGA_FB_TIMEOUT_EN
    .err_timeout    (err_timeout),
`endif
    .mem_addr       (mem_addr),
    .mem_rd         (mem_rd),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          valid_cnt = 0;
  bit          fixed_mode = 1'b1;
  bit          mem_manual = 1'b0;
  int          max_delay = 0;
  int          wait_left = 0;
  logic [21:0] ack_addr = '0;
  logic [21:0] rd_log[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Memory contents as a pure function of halfword address
  function automatic logic [15:0] mem_word(input logic [21:0] a);
    logic [21:0] d;
    if (fixed_mode) begin
      d = a - 22'h2f;
      return {4{d[3:0]}};
    end
    return (a[15:0] * 16'h9e37) ^ {10'd0, a[21:16]} ^ 16'h5a5a;
  endfunction

  // Memory: random wait states, ack with data; a completed read is logged
  // one negedge later, once the DUT has sampled the ack.
  initial begin
    forever begin
      @(negedge clk);
      if (!mem_manual) begin
        if (mem_ack && rst_n) rd_log.push_back(ack_addr);
        if (rst_n && mem_rd) begin
          if (wait_left == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_word(mem_addr);
            ack_addr  = mem_addr;
            wait_left = $urandom_range(max_delay, 0);
          end else begin
            mem_ack = 1'b0;
            wait_left--;
          end
        end else begin
          mem_ack = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (vga_valid) valid_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got %0d exp %0d", 1, 0);
    $fatal(1, "simulation time limit");
  end

  task automatic run_block(input logic [19:0] a, input bit drop3, input bit last, input int exp_lat);
    int          n0;
    int          cyc;
    bit          got;
    logic [21:0] base;
    n0   = rd_log.size();
    cyc  = 0;
    got  = 1'b0;
    base = 22'(a) * 22'd3;
    vga_addr = a;
    vga_sel  = 1'b1;
    while (!got && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (vga_valid) got = 1'b1;
      else if (drop3 && (rd_log.size() - n0) == 2) vga_sel = 1'b0;
    end
    check("valid_seen", 64'(got), 64'(1));
    if (exp_lat != 0) check("latency", 64'(cyc), 64'(exp_lat));
    check("block_data", 64'(vga_data),
          64'({mem_word(base + 22'd2), mem_word(base + 22'd1), mem_word(base)}));
    @(negedge clk);
    #2;
    if (last) vga_sel = 1'b0;
    check("rd_count", 64'(rd_log.size() - n0), 64'(3));
    for (int k = 0; k < 3; k++) begin
      if (n0 + k < rd_log.size())
        check("rd_addr", 64'(rd_log[n0+k]), 64'(base + 22'(k)));
    end
    $display("block addr=%05h lat=%0d data=%012h", a, cyc, vga_data);
  endtask

  initial begin
    int          n0;
    int          v0;
    int          bad;
    int          guard;
    logic [19:0] pend_m;
    logic [19:0] act_m;
    logic [19:0] w;
    bit          we_r;
    bit          sel_r;

    // Reset values
    #12;
    check("rst_valid", 64'(vga_valid), 64'(0));
    check("rst_mem_rd", 64'(mem_rd), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_data", 64'(vga_data), 64'(0));
    check("rst_offset_in", 64'(vga_offset_in), 64'(0));
    check("rst_cfg_rdata", 64'(cfg_rdata), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed block: 0x10 -> reads 0x30..0x32, data 0x333322221111, latency 4
    fixed_mode = 1'b1;
    max_delay  = 0;
    run_block(20'h00010, 1'b0, 1'b1, 4);
    check("directed_data", 64'(vga_data), 64'h0000_3333_2222_1111);
    @(posedge clk);
    #1;
    check("valid_one_cycle", 64'(vga_valid), 64'(0));
    repeat (3) @(negedge clk);

    // Streaming scan-out: 256 consecutive blocks, zero-wait memory
    fixed_mode = 1'b0;
    n0 = rd_log.size();
    v0 = valid_cnt;
    for (int i = 0; i < 256; i++)
      run_block(20'(i), 1'b0, i == 255, (i == 0) ? 4 : 5);
    check("stream_reads", 64'(rd_log.size() - n0), 64'(768));
    check("stream_valids", 64'(valid_cnt - v0), 64'(256));
    bad = 0;
    for (int i = 0; i < 768; i++)
      if (n0 + i < rd_log.size() && rd_log[n0+i] != 22'(i)) bad++;
    check("stream_ascending", 64'(bad), 64'(0));
    repeat (3) @(negedge clk);

    // Random addresses and wait states, sel dropped in third beat of last block
    max_delay = 5;
    for (int i = 0; i < 16; i++)
      run_block(20'($urandom), i == 15, i == 15, 0);
    v0 = valid_cnt;
    repeat (20) @(posedge clk);
    #1;
    check("drop_no_extra_valid", 64'(valid_cnt), 64'(v0));
    check("drop_idle_mem_rd", 64'(mem_rd), 64'(0));
    max_delay = 0;
    @(negedge clk);

    // Offset double buffer, directed
    cfg_we = 1'b1;
    cfg_wdata = 20'h00400;
    @(negedge clk);
    cfg_we = 1'b0;
    check("pend_readback", 64'(cfg_rdata), 64'(20'h00400));
    check("active_unchanged", 64'(vga_offset_in), 64'(0));
    repeat (5) @(negedge clk);
    check("active_still_old", 64'(vga_offset_in), 64'(0));
    vga_offset_sel = 1'b1;
    @(negedge clk);
    vga_offset_sel = 1'b0;
    check("active_promoted", 64'(vga_offset_in), 64'(20'h00400));
    cfg_we = 1'b1;
    cfg_wdata = 20'h00800;
    vga_offset_sel = 1'b1;
    #1;
    check("active_comb_before_edge", 64'(vga_offset_in), 64'(20'h00400));
    @(negedge clk);
    cfg_we = 1'b0;
    vga_offset_sel = 1'b0;
    check("write_through", 64'(vga_offset_in), 64'(20'h00800));
    check("write_through_pend", 64'(cfg_rdata), 64'(20'h00800));

    // Offset double buffer, randomized against model
    pend_m = 20'h00800;
    act_m  = 20'h00800;
    for (int i = 0; i < 40; i++) begin
      we_r  = 1'($urandom_range(1, 0));
      sel_r = 1'($urandom_range(3, 0) == 0);
      w     = 20'($urandom);
      cfg_we = we_r;
      cfg_wdata = w;
      vga_offset_sel = sel_r;
      #1;
      check("rand_active_pre", 64'(vga_offset_in), 64'(act_m));
      if (sel_r) act_m = we_r ? w : pend_m;
      if (we_r) pend_m = w;
      @(negedge clk);
      check("rand_active", 64'(vga_offset_in), 64'(act_m));
      check("rand_pending", 64'(cfg_rdata), 64'(pend_m));
      $display("offset we=%0d sel=%0d wdata=%05h active=%05h pending=%05h",
               we_r, sel_r, w, vga_offset_in, cfg_rdata);
    end
    cfg_we = 1'b1;
    cfg_wdata = 20'h0abcd;
    @(negedge clk);
    cfg_we = 1'b0;

    // Reset asserted during beat 1 aborts the fetch
    n0 = rd_log.size();
    vga_addr = 20'h00123;
    vga_sel  = 1'b1;
    guard = 0;
    while ((rd_log.size() - n0) < 1 && guard < 50) begin
      @(negedge clk);
      #2;
      guard++;
    end
    check("reset_reached_beat1", 64'(rd_log.size() - n0), 64'(1));
    rst_n = 1'b0;
    #1;
    check("reset_mem_rd", 64'(mem_rd), 64'(0));
    check("reset_valid", 64'(vga_valid), 64'(0));
    check("reset_offset", 64'(vga_offset_in), 64'(0));
    check("reset_pending", 64'(cfg_rdata), 64'(0));
    vga_sel = 1'b0;
    mem_manual = 1'b1;
    repeat (2) @(negedge clk);
    mem_ack = 1'b0;
    rst_n = 1'b1;
    v0 = valid_cnt;
    mem_ack = 1'b1;
    mem_rdata = 16'hffff;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("stray_ack_no_valid", 64'(valid_cnt), 64'(v0));
    check("stray_ack_mem_rd", 64'(mem_rd), 64'(0));
    @(negedge clk);
    mem_manual = 1'b0;
    wait_left = 0;
    run_block(20'h00321, 1'b0, 1'b1, 4);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
